// File: rtl/fila_pkg.sv
// Shared types and default widths for the fila queue and its reader.
// Widths here must match the fila instance the reader is attached to.
package fila_pkg;

  localparam int FILA_DATA_W = 8;
  localparam int FILA_LEN_W  = 8;

  typedef logic [FILA_DATA_W-1:0] fila_word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } leitor_state_t;

endpackage

// File: rtl/fila_leitor.sv
// Reader for fila: pops one word per downstream transfer and presents it on a valid/ready port.
// Latency: valid_out rises one edge after a non-zero len_in is seen in IDLE; one word per SETTLE_CYCLES+1 cycles.
// Backpressure: ready_in low holds the word and blocks further pops. FILA_LEITOR_STATS_EN enables count_out.
module fila_leitor
  import fila_pkg::*;
#(
  parameter int DATA_W        = FILA_DATA_W,
  parameter int LEN_W         = FILA_LEN_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              dequeue_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [LEN_W-1:0]  count_out
);

  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  leitor_state_t     state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              deq_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              vld_nxt;
  logic              xfer;

  assign xfer = valid_out && ready_in;

  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dequeue_out <= 1'b0;
      data_out    <= '0;
      valid_out   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      dequeue_out <= deq_nxt;
      data_out    <= data_nxt;
      valid_out   <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    deq_nxt   = 1'b0;
    data_nxt  = data_out;
    vld_nxt   = valid_out && !ready_in;
    case (state)
      IDLE: begin
        if (len_in != '0) begin
          data_nxt  = data_in;
          deq_nxt   = 1'b1;
          vld_nxt   = 1'b1;
          cnt_nxt   = CNT_W'(SETTLE_CYCLES);
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // len_in is stale until fila has applied the pop, so it is not looked at here.
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = vld_nxt ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (xfer) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
      end
    endcase
  end

`ifdef FILA_LEITOR_STATS_EN
  logic [LEN_W-1:0] count_q;

  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (xfer) begin
      count_q <= count_q + LEN_W'(1);
    end
  end

  assign count_out = count_q;
`else
  assign count_out = '0;
`endif

endmodule

// File: tb/tb_fila_leitor.sv
// Bench for fila_leitor with a behavioural fila model and a scoreboard-driven sink monitor.
`timescale 1ns/1ps
module tb_fila_leitor;
  import fila_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk_10KHz = 1'b0;
  logic          reset     = 1'b0;
  logic [LW-1:0] len_in    = '0;
  logic [DW-1:0] data_in   = '0;
  logic          dequeue_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in  = 1'b0;
  logic [LW-1:0] count_out;

  always #50000 clk_10KHz = ~clk_10KHz;

  fila_leitor #(.DATA_W(DW), .LEN_W(LW), .SETTLE_CYCLES(1)) dut (
    .clk_10KHz  (clk_10KHz),
    .reset      (reset),
    .len_in     (len_in),
    .data_in    (data_in),
    .dequeue_out(dequeue_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .count_out  (count_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural fila: pop on dequeue pulse, push on enq_vld, len/head registered.
  fila_word_t fifo_q[$];
  logic       enq_vld = 1'b0;
  fila_word_t enq_dat = '0;
  int         pulse_cnt = 0;

  always @(posedge clk_10KHz) begin
    if (dequeue_out) begin
      pulse_cnt++;
      total++;
      if (fifo_q.size() == 0) begin
        bad++;
        $display("FAIL pop_empty: dequeue with len 0 at %0t", $time);
      end else begin
        void'(fifo_q.pop_front());
      end
    end
    if (enq_vld) fifo_q.push_back(enq_dat);
    len_in  <= LW'(fifo_q.size());
    data_in <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // Scoreboard
  fila_word_t exp_q[$];
  int         exp_cnt = 0;

  function automatic longint exp_count();
`ifdef FILA_LEITOR_STATS_EN
    return longint'(exp_cnt % 256);
`else
    return 0;
`endif
  endfunction

  logic       prev_vld  = 1'b0;
  logic       prev_xfer = 1'b0;
  fila_word_t prev_dat  = '0;

  always @(negedge clk_10KHz) begin
    #1;
    if (reset) begin
      chk("count_track", longint'(count_out), exp_count());
      if (prev_vld && !prev_xfer && valid_out)
        chk("data_stable", longint'(data_out), longint'(prev_dat));
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", data_out);
        end else begin
          chk("sink_data", longint'(data_out), longint'(exp_q.pop_front()));
        end
        exp_cnt++;
      end
      prev_vld  = valid_out;
      prev_xfer = valid_out && ready_in;
      prev_dat  = data_out;
    end else begin
      prev_vld = 1'b0;
    end
  end

  task automatic enq_words(input fila_word_t w[$]);
    foreach (w[i]) begin
      @(negedge clk_10KHz);
      enq_vld = 1'b1;
      enq_dat = w[i];
      exp_q.push_back(w[i]);
    end
    @(negedge clk_10KHz);
    enq_vld = 1'b0;
  endtask

  task automatic drain(input string nm, input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk_10KHz);
      n++;
    end
    chk(nm, longint'(exp_q.size()), 0);
  endtask

  initial begin
    #(3000 * 100000);
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    fila_word_t w[$];

    // Reset state
    repeat (3) @(negedge clk_10KHz);
    chk("rst_deq", dequeue_out, 0);
    chk("rst_vld", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_count", count_out, 0);
    reset = 1'b1;

    // Empty queue, ready toggling
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_10KHz);
      ready_in = i[0];
      chk("empty_vld", valid_out, 0);
    end
    chk("empty_pulses", pulse_cnt - p0, 0);

    // Single word
    ready_in = 1'b1;
    p0 = pulse_cnt;
    w = '{8'h11};
    enq_words(w);
    drain("single_drain", 20);
    repeat (20) @(negedge clk_10KHz);
    chk("single_pulses", pulse_cnt - p0, 1);
    chk("single_len", len_in, 0);
    chk("single_vld", valid_out, 0);

    // Reset while holding a word
    ready_in = 1'b0;
    w = '{8'h5A};
    enq_words(w);
    n = 0;
    while (!valid_out && n < 10) begin
      @(negedge clk_10KHz);
      n++;
    end
    chk("hold_vld_seen", valid_out, 1);
    repeat (3) @(negedge clk_10KHz);
    chk("hold_data", data_out, 8'h5A);
    reset = 1'b0;
    #1;
    chk("midrst_deq", dequeue_out, 0);
    chk("midrst_vld", valid_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_count", count_out, 0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(negedge clk_10KHz);
    reset = 1'b1;

    // Nine-word burst
    ready_in = 1'b1;
    p0 = pulse_cnt;
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    enq_words(w);
    drain("burst_drain", 100);
    repeat (5) @(negedge clk_10KHz);
    chk("burst_pulses", pulse_cnt - p0, 9);
    chk("burst_len", len_in, 0);
`ifdef FILA_LEITOR_STATS_EN
    chk("burst_count", count_out, 9);
`else
    chk("burst_count", count_out, 0);
`endif

    // Stalled sink
    ready_in = 1'b0;
    p0 = pulse_cnt;
    w = '{8'h22, 8'h33};
    enq_words(w);
    repeat (10) @(negedge clk_10KHz);
    chk("stall_data", data_out, 8'h22);
    chk("stall_vld", valid_out, 1);
    chk("stall_pulses", pulse_cnt - p0, 1);
    chk("stall_len", len_in, 1);
    ready_in = 1'b1;
    drain("stall_drain", 20);
    repeat (5) @(negedge clk_10KHz);
    chk("stall_pulses2", pulse_cnt - p0, 2);
    chk("stall_len2", len_in, 0);
`ifdef FILA_LEITOR_STATS_EN
    chk("stall_count", count_out, 11);
`else
    chk("stall_count", count_out, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
